// File: rtl/hdlc_rx_monitor_pkg.sv
// Shared definitions for the HDLC receive monitor.
//   state_e      : per-channel framing state (HUNT / FRAME)
//   FLAG_PATTERN : opening/closing flag octet
//   ABORT_RUN    : ones-run length that signals an abort
//   STUFF_RUN    : ones-run length after which a zero is a stuffed bit
//   *_width()    : width helpers shared by the top, channel and bench
package hdlc_mon_pkg;

  typedef enum logic {HUNT = 1'b0, FRAME = 1'b1} state_e;

  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  localparam int         ABORT_RUN    = 7;
  localparam int         STUFF_RUN    = 5;

  function automatic int bc_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Destuffed bit counter: payload limit plus the closing flag plus the
  // overflow bit, so it saturates before it can wrap.
  function automatic int bits_width(input int max_bytes);
    return $clog2(8 * max_bytes + 17);
  endfunction

  // The run counter must reach both the abort length and the idle length.
  function automatic int run_width(input int idle_ones);
    return $clog2(((idle_ones > ABORT_RUN) ? idle_ones : ABORT_RUN) + 1);
  endfunction

endpackage

// File: rtl/hdlc_rx_monitor_if.sv
// Bundle of the per-channel tap inputs and monitor outputs.
//   master : drives the serial taps and the error-counter clear
//   slave  : the monitor; consumes taps, drives status outputs
interface hdlc_rx_monitor_if #(
  parameter int NUM_CH    = 4,
  parameter int BC_W      = 8,
  parameter int ERR_CNT_W = 8
);
  logic [NUM_CH-1:0]           i_rx;
  logic [NUM_CH-1:0]           i_rx_en;
  logic                        i_clr_err;
  logic [NUM_CH-1:0]           o_valid_frame;
  logic [NUM_CH-1:0]           o_flag_detect;
  logic [NUM_CH-1:0]           o_abort_detect;
  logic [NUM_CH-1:0]           o_idle;
  logic [NUM_CH-1:0]           o_eof;
  logic [NUM_CH-1:0]           o_frame_err;
  logic [NUM_CH-1:0]           o_overflow;
  logic [NUM_CH*BC_W-1:0]      o_byte_count;
  logic [NUM_CH*ERR_CNT_W-1:0] o_err_cnt;

  modport master (
    output i_rx, i_rx_en, i_clr_err,
    input  o_valid_frame, o_flag_detect, o_abort_detect, o_idle, o_eof,
           o_frame_err, o_overflow, o_byte_count, o_err_cnt
  );

  modport slave (
    input  i_rx, i_rx_en, i_clr_err,
    output o_valid_frame, o_flag_detect, o_abort_detect, o_idle, o_eof,
           o_frame_err, o_overflow, o_byte_count, o_err_cnt
  );
endinterface

// File: rtl/hdlc_rx_monitor_ch.sv
// One HDLC receive monitor channel.
// Inputs : i_clk, i_rst (sync, active-high), i_rx serial bit, i_rx_en bit
//          strobe, i_clr_err error-counter clear.
// Outputs: registered framing status for the bit accepted last cycle --
//          valid_frame/idle/overflow levels, flag/abort/eof/frame_err
//          pulses, byte_count and saturating err_cnt.
module hdlc_rx_monitor_ch
  import hdlc_mon_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter int IDLE_ONES = 8,
  parameter int ERR_CNT_W = 8,
  parameter int BC_W      = bc_width(MAX_BYTES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_rx_en,
  input  logic                 i_clr_err,
  output logic                 o_valid_frame,
  output logic                 o_flag_detect,
  output logic                 o_abort_detect,
  output logic                 o_idle,
  output logic                 o_eof,
  output logic                 o_frame_err,
  output logic                 o_overflow,
  output logic [BC_W-1:0]      o_byte_count,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int BIT_W = bits_width(MAX_BYTES);
  localparam int RUN_W = run_width(IDLE_ONES);
  localparam logic [BIT_W-1:0] BITS_MAX  = BIT_W'(8 * MAX_BYTES + 16);
  localparam logic [BIT_W-1:0] OVF_LIMIT = BIT_W'(8 * MAX_BYTES + 8);

  state_e           r_state;
  logic [7:0]       r_sh;
  logic [RUN_W-1:0] r_run;
  logic [BIT_W-1:0] r_bits;

  state_e              w_state_next;
  logic [7:0]          w_sh;
  logic [RUN_W-1:0]    w_run;
  logic [BIT_W-1:0]    w_bits, w_payload, w_bits_next;
  logic [BC_W-1:0]     w_bc_next;
  logic                w_flag, w_abort, w_stuffed, w_b2b;
  logic                w_eof, w_frame_err, w_frame_abort, w_ovf_rise, w_ovf_next;
  logic [1:0]          w_inc;

  function automatic logic [BC_W-1:0] sat_bc(input logic [BIT_W-1:0] v);
    if (v > BIT_W'(MAX_BYTES)) return BC_W'(MAX_BYTES);
    return v[BC_W-1:0];
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_err(input logic [ERR_CNT_W-1:0] c,
                                                   input logic [1:0] inc);
    logic [ERR_CNT_W+1:0] sum;
    sum = {2'b00, c} + (ERR_CNT_W+2)'(inc);
    if (sum > {2'b00, {ERR_CNT_W{1'b1}}}) return {ERR_CNT_W{1'b1}};
    return sum[ERR_CNT_W-1:0];
  endfunction

  always_comb begin
    w_sh      = {r_sh[6:0], i_rx};
    w_run     = i_rx ? ((r_run == {RUN_W{1'b1}}) ? r_run : r_run + 1'b1) : '0;
    w_flag    = (w_sh == FLAG_PATTERN);
    // Edge of the run (6 -> 7), so a long run of ones aborts only once.
    w_abort   = i_rx && (r_run == RUN_W'(ABORT_RUN - 1));
    w_stuffed = !i_rx && (r_run == RUN_W'(STUFF_RUN));
    w_bits    = (w_stuffed || r_bits == BITS_MAX) ? r_bits : r_bits + 1'b1;
    // Count includes the closing flag's 8 bits; strip them for the payload.
    w_payload = w_bits - BIT_W'(8);
    w_b2b     = (w_bits == BIT_W'(8));

    w_state_next  = r_state;
    w_bits_next   = r_bits;
    w_bc_next     = o_byte_count;
    w_ovf_next    = o_overflow;
    w_eof         = 1'b0;
    w_frame_err   = 1'b0;
    w_frame_abort = 1'b0;
    w_ovf_rise    = 1'b0;

    if (r_state == HUNT) begin
      if (w_flag) begin
        w_state_next = FRAME;
        w_bits_next  = '0;
        w_bc_next    = '0;
        w_ovf_next   = 1'b0;
      end
    end else begin
      w_ovf_rise  = !o_overflow && (w_bits > OVF_LIMIT);
      w_ovf_next  = o_overflow || w_ovf_rise;
      w_bits_next = w_bits;
      w_bc_next   = sat_bc(w_bits >> 3);
      if (w_abort) begin
        w_state_next  = HUNT;
        w_frame_abort = 1'b1;
      end else if (w_flag && w_b2b) begin
        w_bits_next = '0;
        w_bc_next   = '0;
      end else if (w_flag) begin
        w_state_next = HUNT;
        w_eof        = 1'b1;
        w_frame_err  = (w_payload[2:0] != 3'd0);
        w_bc_next    = sat_bc(w_payload >> 3);
      end
    end

    w_inc = 2'(w_frame_abort) + 2'(w_frame_err) + 2'(w_ovf_rise);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= HUNT;
      r_sh           <= '0;
      r_run          <= '0;
      r_bits         <= '0;
      o_valid_frame  <= 1'b0;
      o_flag_detect  <= 1'b0;
      o_abort_detect <= 1'b0;
      o_idle         <= 1'b0;
      o_eof          <= 1'b0;
      o_frame_err    <= 1'b0;
      o_overflow     <= 1'b0;
      o_byte_count   <= '0;
      o_err_cnt      <= '0;
    end else begin
      o_flag_detect  <= 1'b0;
      o_abort_detect <= 1'b0;
      o_eof          <= 1'b0;
      o_frame_err    <= 1'b0;
      if (i_rx_en) begin
        r_state        <= w_state_next;
        r_sh           <= w_sh;
        r_run          <= w_run;
        r_bits         <= w_bits_next;
        o_valid_frame  <= (w_state_next == FRAME);
        o_flag_detect  <= w_flag;
        o_abort_detect <= w_abort;
        o_idle         <= (w_state_next == HUNT) && (w_run >= RUN_W'(IDLE_ONES));
        o_eof          <= w_eof;
        o_frame_err    <= w_frame_err;
        o_overflow     <= w_ovf_next;
        o_byte_count   <= w_bc_next;
      end
      // Clear takes precedence over any increment landing in the same cycle.
      if (i_clr_err)    o_err_cnt <= '0;
      else if (i_rx_en) o_err_cnt <= sat_err(o_err_cnt, w_inc);
    end
  end

endmodule

// File: rtl/hdlc_rx_monitor.sv
// Multi-channel HDLC receive-side protocol monitor.
// Ports: i_clk, i_rst (sync, active-high) and the slave side of
//        hdlc_rx_monitor_if carrying per-channel taps and status.
// Each channel is an independent hdlc_rx_monitor_ch; only the error
// counter clear is shared.
module hdlc_rx_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_BYTES = 128,
  parameter int IDLE_ONES = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hdlc_rx_monitor_if.slave   bus
);

  localparam int BC_W = bc_width(MAX_BYTES);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hdlc_rx_monitor_ch #(
      .MAX_BYTES (MAX_BYTES),
      .IDLE_ONES (IDLE_ONES),
      .ERR_CNT_W (ERR_CNT_W),
      .BC_W      (BC_W)
    ) u_ch (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_rx           (bus.i_rx[g]),
      .i_rx_en        (bus.i_rx_en[g]),
      .i_clr_err      (bus.i_clr_err),
      .o_valid_frame  (bus.o_valid_frame[g]),
      .o_flag_detect  (bus.o_flag_detect[g]),
      .o_abort_detect (bus.o_abort_detect[g]),
      .o_idle         (bus.o_idle[g]),
      .o_eof          (bus.o_eof[g]),
      .o_frame_err    (bus.o_frame_err[g]),
      .o_overflow     (bus.o_overflow[g]),
      .o_byte_count   (bus.o_byte_count[g*BC_W +: BC_W]),
      .o_err_cnt      (bus.o_err_cnt[g*ERR_CNT_W +: ERR_CNT_W])
    );
  end

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Directed bench for hdlc_rx_monitor: frame table plus hand-timed sequences.
module tb_hdlc_rx_monitor;
  import hdlc_mon_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int MAX_BYTES = 4;
  localparam int IDLE_ONES = 8;
  localparam int ERR_CNT_W = 8;
  localparam int BC_W      = bc_width(MAX_BYTES);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdlc_rx_monitor_if #(.NUM_CH(NUM_CH), .BC_W(BC_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

  hdlc_rx_monitor #(
    .NUM_CH(NUM_CH), .MAX_BYTES(MAX_BYTES), .IDLE_ONES(IDLE_ONES), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int          ch;
    logic [63:0] pat;
    int          n;
    int          eof;
    int          bc;
    int          fe;
    int          abort;
    int          err;
  } vec_t;

  vec_t tbl[5];
  int checks = 0;
  int failures = 0;
  int eof_cnt[NUM_CH], fe_cnt[NUM_CH], abort_cnt[NUM_CH], fe_wo_eof[NUM_CH];
  int eof_bc[NUM_CH];
  int gap_pulses;
  logic [31:0] s6 = {8'h7E, 16'h55AA, 8'h7E};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bc(input int ch);
    return int'(bus.o_byte_count[ch*BC_W +: BC_W]);
  endfunction

  function automatic int errc(input int ch);
    return int'(bus.o_err_cnt[ch*ERR_CNT_W +: ERR_CNT_W]);
  endfunction

  task automatic clear_acc();
    for (int c = 0; c < NUM_CH; c++) begin
      eof_cnt[c] = 0; fe_cnt[c] = 0; abort_cnt[c] = 0; fe_wo_eof[c] = 0; eof_bc[c] = -1;
    end
  endtask

  // Present one cycle of inputs, then sample the registered outputs.
  task automatic tick(input logic [NUM_CH-1:0] rx, input logic [NUM_CH-1:0] en, input logic clr);
    bus.i_rx = rx; bus.i_rx_en = en; bus.i_clr_err = clr;
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.o_eof[c]) begin eof_cnt[c]++; eof_bc[c] = bc(c); end
      if (bus.o_frame_err[c]) begin
        fe_cnt[c]++;
        if (!bus.o_eof[c]) fe_wo_eof[c]++;
      end
      if (bus.o_abort_detect[c]) abort_cnt[c]++;
    end
    bus.i_rx_en = '0; bus.i_clr_err = 1'b0;
  endtask

  // Send n bits MSB-first on one channel.
  task automatic send(input int ch, input logic [63:0] pat, input int n);
    logic [NUM_CH-1:0] rx, en;
    for (int i = n - 1; i >= 0; i--) begin
      rx = '0; en = '0;
      rx[ch] = pat[i]; en[ch] = 1'b1;
      tick(rx, en, 1'b0);
    end
  endtask

  initial begin
    logic [NUM_CH-1:0] rx, en;
    tbl[0] = '{0, 64'({8'h7E, 9'b111110111, 8'h7E}), 25, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 64'({8'h7E, 12'h555, 8'h7E}), 28, 1, 1, 1, 0, 1};
    tbl[2] = '{1, 64'({8'h7E, 8'h7E, 8'h55, 8'h7E}), 32, 1, 1, 0, 0, 1};
    tbl[3] = '{1, 64'({8'h7E, 24'h123456, 8'h7E}), 40, 1, 3, 0, 0, 1};
    tbl[4] = '{1, 64'({8'h7E, 7'h55, 8'h7E}), 23, 1, 0, 1, 0, 2};

    rst = 1'b1;
    bus.i_rx = '0; bus.i_rx_en = '0; bus.i_clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.o_valid_frame, 0);
    check("rst_idle", bus.o_idle, 0);
    check("rst_ovf", bus.o_overflow, 0);
    check("rst_bc", bus.o_byte_count, 0);
    check("rst_err", bus.o_err_cnt, 0);
    rst = 1'b0;

    // Idle ones, then a 2-byte frame on ch0.
    clear_acc();
    send(0, 64'h7F, 7);
    check("t1_idle_7ones", bus.o_idle[0], 0);
    send(0, 64'h1, 1);
    check("t1_idle_8ones", bus.o_idle[0], 1);
    send(0, 64'hFF, 8);
    check("t1_idle_16ones", bus.o_idle[0], 1);
    check("t1_abort_once_hunt", abort_cnt[0], 1);
    check("t1_err_hunt_abort", errc(0), 0);
    send(0, 64'h7E, 8);
    check("t1_flag", bus.o_flag_detect[0], 1);
    check("t1_vf_rise", bus.o_valid_frame[0], 1);
    check("t1_idle_off", bus.o_idle[0], 0);
    send(0, 64'h55AA, 16);
    check("t1_live_bc", bc(0), 2);
    send(0, 64'h3F, 7);
    check("t1_vf_before_close", bus.o_valid_frame[0], 1);
    check("t1_no_early_eof", eof_cnt[0], 0);
    send(0, 64'h0, 1);
    check("t1_eof", bus.o_eof[0], 1);
    check("t1_vf_fall", bus.o_valid_frame[0], 0);
    check("t1_bc", bc(0), 2);
    check("t1_fe", bus.o_frame_err[0], 0);
    check("t1_err", errc(0), 0);

    // Frame table.
    for (int r = 0; r < 5; r++) begin
      clear_acc();
      send(tbl[r].ch, tbl[r].pat, tbl[r].n);
      check($sformatf("tbl%0d_eof", r), eof_cnt[tbl[r].ch], tbl[r].eof);
      check($sformatf("tbl%0d_bc", r), eof_bc[tbl[r].ch], tbl[r].bc);
      check($sformatf("tbl%0d_fe", r), fe_cnt[tbl[r].ch], tbl[r].fe);
      check($sformatf("tbl%0d_fe_align", r), fe_wo_eof[tbl[r].ch], 0);
      check($sformatf("tbl%0d_abort", r), abort_cnt[tbl[r].ch], tbl[r].abort);
      check($sformatf("tbl%0d_err", r), errc(tbl[r].ch), tbl[r].err);
    end

    // Abort inside a frame on ch0.
    clear_acc();
    send(0, 64'h7E, 8);
    send(0, 64'h2AA, 10);
    send(0, 64'h0, 1);
    send(0, 64'h3F, 6);
    check("t3_vf_6ones", bus.o_valid_frame[0], 1);
    check("t3_no_abort_6", abort_cnt[0], 0);
    send(0, 64'h1, 1);
    check("t3_abort", bus.o_abort_detect[0], 1);
    check("t3_vf_fall", bus.o_valid_frame[0], 0);
    check("t3_err", errc(0), 1);
    send(0, 64'h1, 1);
    check("t3_abort_once", bus.o_abort_detect[0], 0);
    check("t3_idle_after", bus.o_idle[0], 1);
    check("t3_no_eof", eof_cnt[0], 0);

    // Overflow on ch3 with MAX_BYTES=4.
    clear_acc();
    send(3, 64'h7E, 8);
    send(3, 64'h55_5555_5555, 40);
    check("t4_ovf_at40", bus.o_overflow[3], 0);
    check("t4_live_bc_sat", bc(3), 4);
    send(3, 64'h0, 1);
    check("t4_ovf_at41", bus.o_overflow[3], 1);
    check("t4_err_ovf", errc(3), 1);
    send(3, 64'h7E, 7);
    check("t4_eof", eof_cnt[3], 1);
    check("t4_bc", eof_bc[3], 4);
    check("t4_fe", fe_cnt[3], 0);
    check("t4_ovf_hold", bus.o_overflow[3], 1);
    check("t4_err_hold", errc(3), 1);
    send(3, 64'h7E, 8);
    check("t4_ovf_clear", bus.o_overflow[3], 0);
    check("t4_vf_reopen", bus.o_valid_frame[3], 1);

    // ch2 with RxEn every other cycle alongside gapless ch0.
    clear_acc();
    gap_pulses = 0;
    for (int c = 0; c < 64; c++) begin
      rx = '0; en = '0;
      if (c < 32) begin rx[0] = s6[31-c]; en[0] = 1'b1; end
      if (c % 2 == 1) begin rx[2] = s6[31-(c/2)]; en[2] = 1'b1; end
      else rx[2] = ~s6[31-(c/2)];
      tick(rx, en, 1'b0);
      if (!en[2])
        gap_pulses += int'(bus.o_eof[2] | bus.o_flag_detect[2] |
                           bus.o_abort_detect[2] | bus.o_frame_err[2]);
    end
    check("t6_ch0_eof", eof_cnt[0], 1);
    check("t6_ch0_bc", eof_bc[0], 2);
    check("t6_ch2_eof", eof_cnt[2], 1);
    check("t6_ch2_bc", eof_bc[2], 2);
    check("t6_ch2_fe", fe_cnt[2], 0);
    check("t6_gap_pulses", gap_pulses, 0);

    // Reset in the middle of a ch2 frame.
    clear_acc();
    send(2, 64'({8'h7E, 10'h2AA}), 18);
    check("t6_vf_mid", bus.o_valid_frame[2], 1);
    rst = 1'b1;
    tick('0, '0, 1'b0);
    rst = 1'b0;
    check("t6_rst_vf", bus.o_valid_frame, 0);
    check("t6_rst_idle", bus.o_idle, 0);
    check("t6_rst_bc", bus.o_byte_count, 0);
    check("t6_rst_err", bus.o_err_cnt, 0);
    send(2, 64'h7E, 8);
    check("t6_no_eof_after_rst", eof_cnt[2], 0);
    check("t6_vf_reopen", bus.o_valid_frame[2], 1);

    // ClrErr coincident with an in-frame abort.
    send(2, 64'({4'hA, 8'h7E}), 12);
    check("t6_fe_err", errc(2), 1);
    send(2, 64'h7E, 8);
    send(2, 64'h3F, 7);
    rx = '0; en = '0; rx[2] = 1'b1; en[2] = 1'b1;
    tick(rx, en, 1'b1);
    check("t6_clr_abort", bus.o_abort_detect[2], 1);
    check("t6_clr_vf", bus.o_valid_frame[2], 0);
    check("t6_clr_wins", errc(2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
